// File: rtl/bip_control_v2.sv
// Accumulator-machine sequencer: fetch, decode, RAM-wait, branch and halt control.
// Decode strobes are registered when the instruction is latched; WrAcc is gated by RamReady.
module bip_control_v2 #(
    parameter int PC_W    = 11,
    parameter int OP_W    = 5,
    parameter int INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               InstrValid,
    input  logic               AccZero,
    input  logic               AccNeg,
    input  logic               RamReady,
    output logic [PC_W-1:0]    Addr,
    output logic [1:0]         SelA,
    output logic               SelB,
    output logic               WrAcc,
    output logic               Op,
    output logic               WrRam,
    output logic               RdRam,
    output logic [PC_W-1:0]    Operand,
    output logic               Halted
);

    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STO  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(11);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_RAM = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [1:0]          sel_a_q, sel_a_d;
    logic                sel_b_q, sel_b_d;
    logic                op_q, op_d;
    logic                wr_ram_q, wr_ram_d;
    logic                rd_ram_q, rd_ram_d;
    logic                acc_wr_en_q, acc_wr_en_d;
    logic                ram_instr_q, ram_instr_d;
    logic                halted_q, halted_d;

    logic [OP_W-1:0]     fetch_op, ir_op;
    logic [PC_W-1:0]     operand;
    logic [1:0]          dec_sel_a;
    logic                dec_sel_b, dec_op, dec_wr_ram, dec_rd_ram, dec_acc_wr, dec_ram;
    logic                taken, complete;

    assign fetch_op = Instruction[INSTR_W-1 -: OP_W];
    assign ir_op    = ir_q[INSTR_W-1 -: OP_W];
    assign operand  = ir_q[PC_W-1:0];

    // Decode the incoming word so strobes are already valid in the first EXEC cycle.
    always_comb begin
        dec_sel_a  = 2'b00;
        dec_sel_b  = 1'b0;
        dec_op     = 1'b0;
        dec_wr_ram = 1'b0;
        dec_rd_ram = 1'b0;
        dec_acc_wr = 1'b0;
        dec_ram    = 1'b0;
        case (fetch_op)
            OP_STO:  begin dec_wr_ram = 1'b1; dec_ram = 1'b1; end
            OP_LD:   begin dec_rd_ram = 1'b1; dec_ram = 1'b1; dec_acc_wr = 1'b1; end
            OP_LDI:  begin dec_sel_a = 2'b01; dec_acc_wr = 1'b1; end
            OP_ADD:  begin dec_rd_ram = 1'b1; dec_ram = 1'b1; dec_sel_b = 1'b1;
                           dec_sel_a = 2'b10; dec_acc_wr = 1'b1; end
            OP_ADDI: begin dec_sel_a = 2'b10; dec_acc_wr = 1'b1; end
            OP_SUB:  begin dec_rd_ram = 1'b1; dec_ram = 1'b1; dec_sel_b = 1'b1;
                           dec_sel_a = 2'b10; dec_acc_wr = 1'b1; dec_op = 1'b1; end
            OP_SUBI: begin dec_sel_a = 2'b10; dec_acc_wr = 1'b1; dec_op = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ir_op)
            OP_BEQ:  taken = AccZero;
            OP_BNE:  taken = !AccZero;
            OP_BLT:  taken = AccNeg;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        op_d        = op_q;
        wr_ram_d    = wr_ram_q;
        rd_ram_d    = rd_ram_q;
        acc_wr_en_d = acc_wr_en_q;
        ram_instr_d = ram_instr_q;
        halted_d    = halted_q;
        complete    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (InstrValid) begin
                    ir_d        = Instruction;
                    sel_a_d     = dec_sel_a;
                    sel_b_d     = dec_sel_b;
                    op_d        = dec_op;
                    wr_ram_d    = dec_wr_ram;
                    rd_ram_d    = dec_rd_ram;
                    acc_wr_en_d = dec_acc_wr;
                    ram_instr_d = dec_ram;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ir_op == OP_HLT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!ram_instr_q || RamReady) begin
                    complete = 1'b1;
                end else begin
                    state_d = S_WAIT_RAM;
                end
            end
            S_WAIT_RAM: begin
                complete = RamReady;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        if (complete) begin
            pc_d    = taken ? operand : pc_q + PC_W'(1);
            state_d = S_FETCH;
        end

        // Strobes drop as soon as the machine leaves EXEC/WAIT_RAM.
        if (state_d == S_FETCH || state_d == S_HALT) begin
            if (state_q != S_FETCH) begin
                sel_a_d     = 2'b00;
                sel_b_d     = 1'b0;
                op_d        = 1'b0;
                wr_ram_d    = 1'b0;
                rd_ram_d    = 1'b0;
                acc_wr_en_d = 1'b0;
                ram_instr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            sel_a_q     <= 2'b00;
            sel_b_q     <= 1'b0;
            op_q        <= 1'b0;
            wr_ram_q    <= 1'b0;
            rd_ram_q    <= 1'b0;
            acc_wr_en_q <= 1'b0;
            ram_instr_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            op_q        <= op_d;
            wr_ram_q    <= wr_ram_d;
            rd_ram_q    <= rd_ram_d;
            acc_wr_en_q <= acc_wr_en_d;
            ram_instr_q <= ram_instr_d;
            halted_q    <= halted_d;
        end
    end

    assign Addr    = pc_q;
    assign SelA    = sel_a_q;
    assign SelB    = sel_b_q;
    assign Op      = op_q;
    assign WrRam   = wr_ram_q;
    assign RdRam   = rd_ram_q;
    assign Operand = operand;
    assign Halted  = halted_q;
    assign WrAcc   = acc_wr_en_q && (state_q == S_EXEC || state_q == S_WAIT_RAM)
                     && (!ram_instr_q || RamReady);

endmodule

// File: tb/tb_bip_control_v2.sv
// Directed bench: per-cycle expected output vectors queued up front, popped and compared each cycle.
module tb_bip_control_v2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Instruction = '0;
    logic        InstrValid = 1'b0;
    logic        AccZero = 1'b0;
    logic        AccNeg = 1'b0;
    logic        RamReady = 1'b0;
    logic [10:0] Addr;
    logic [1:0]  SelA;
    logic        SelB, WrAcc, Op, WrRam, RdRam, Halted;
    logic [10:0] Operand;

    bip_control_v2 dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
        .AccZero(AccZero), .AccNeg(AccNeg), .RamReady(RamReady), .Addr(Addr),
        .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam),
        .RdRam(RdRam), .Operand(Operand), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [29:0] exp;
    } exp_t;

    exp_t        sbq[$];
    bit          rdy_q[$];
    bit          vld_q[$];
    logic [15:0] prog [0:2047];
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADD = 5'd4,
                           ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7, BEQ = 5'd8, BNE = 5'd9,
                           BLT = 5'd10, JMP = 5'd11, NOPX = 5'd31;

    function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
        return {opc, opd};
    endfunction

    // Vector order: Addr, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand, Halted
    task automatic push(input string tag, input logic [10:0] addr, input logic [1:0] sa,
                        input bit sb, input bit wa, input bit op, input bit wr, input bit rd,
                        input logic [10:0] opd, input bit h);
        exp_t e;
        e.tag = tag;
        e.exp = {addr, sa, sb, wa, op, wr, rd, opd, h};
        sbq.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [29:0] obs;
        obs = {Addr, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand, Halted};
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: got %h required a queued entry", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            Instruction = prog[Addr];
            RamReady    = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
            InstrValid  = (vld_q.size() > 0) ? vld_q.pop_front() : 1'b1;
            #1;
            check_next();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        InstrValid = 1'b0;
        RamReady = 1'b0;
        AccZero = 1'b0;
        AccNeg = 1'b0;
        Instruction = '0;
        for (int i = 0; i < 2048; i++) prog[i] = ins(NOPX, 11'd0);
        rdy_q.delete();
        vld_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    logic [4:0]  br_op [6] = '{BEQ, BEQ, BNE, BNE, BLT, BLT};
    bit          br_z  [6] = '{1, 0, 0, 1, 0, 0};
    bit          br_n  [6] = '{0, 0, 0, 0, 1, 0};
    logic [10:0] br_to [6] = '{11'd20, 11'd1, 11'd20, 11'd1, 11'd20, 11'd1};

    initial begin
        // Reset state while Reset is still high
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        push("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_next();

        // LDI 5, ADDI 3, STO 7, HLT
        do_reset();
        prog[0] = ins(LDI, 5); prog[1] = ins(ADDI, 3); prog[2] = ins(STO, 7); prog[3] = ins(HLT, 0);
        push("p1_fetch0", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("p1_ldi",    0, 2'b01, 0, 1, 0, 0, 0, 5, 0);
        push("p1_fetch1", 1, 2'b00, 0, 0, 0, 0, 0, 5, 0);
        push("p1_addi",   1, 2'b10, 0, 1, 0, 0, 0, 3, 0);
        push("p1_fetch2", 2, 2'b00, 0, 0, 0, 0, 0, 3, 0);
        push("p1_sto",    2, 2'b00, 0, 0, 0, 1, 0, 7, 0);
        push("p1_fetch3", 3, 2'b00, 0, 0, 0, 0, 0, 7, 0);
        push("p1_hlt",    3, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push("p1_halted", 3, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        run(11);

        // LD 4 with RamReady low for three EXEC/WAIT_RAM cycles
        do_reset();
        prog[0] = ins(LD, 4);
        rdy_q = '{1, 0, 0, 0, 1};
        push("ld_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push("ld_wait", 0, 2'b00, 0, 0, 0, 0, 1, 4, 0);
        push("ld_done",  0, 2'b00, 0, 1, 0, 0, 1, 4, 0);
        push("ld_next",  1, 2'b00, 0, 0, 0, 0, 0, 4, 0);
        run(6);

        // ADD, SUB, SUBI
        do_reset();
        prog[0] = ins(ADD, 3); prog[1] = ins(SUB, 4); prog[2] = ins(SUBI, 2);
        push("ar_fetch0", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("ar_add",    0, 2'b10, 1, 1, 0, 0, 1, 3, 0);
        push("ar_fetch1", 1, 2'b00, 0, 0, 0, 0, 0, 3, 0);
        push("ar_sub",    1, 2'b10, 1, 1, 1, 0, 1, 4, 0);
        push("ar_fetch2", 2, 2'b00, 0, 0, 0, 0, 0, 4, 0);
        push("ar_subi",   2, 2'b10, 0, 1, 1, 0, 0, 2, 0);
        push("ar_fetch3", 3, 2'b00, 0, 0, 0, 0, 0, 2, 0);
        run(7);

        // Conditional branches, taken and not taken
        for (int k = 0; k < 6; k++) begin
            do_reset();
            prog[0] = ins(br_op[k], 20);
            AccZero = br_z[k];
            AccNeg  = br_n[k];
            push("br_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
            push("br_exec",  0, 2'b00, 0, 0, 0, 0, 0, 20, 0);
            push("br_target", br_to[k], 2'b00, 0, 0, 0, 0, 0, 20, 0);
            run(3);
        end

        // JMP to the last address, then ADDI there wraps the PC to 0
        do_reset();
        prog[0] = ins(JMP, 11'd2047); prog[2047] = ins(ADDI, 1);
        push("wr_fetch0", 0,    2'b00, 0, 0, 0, 0, 0, 0,    0);
        push("wr_jmp",    0,    2'b00, 0, 0, 0, 0, 0, 2047, 0);
        push("wr_fetch",  2047, 2'b00, 0, 0, 0, 0, 0, 2047, 0);
        push("wr_addi",   2047, 2'b10, 0, 1, 0, 0, 0, 1,    0);
        push("wr_wrap",   0,    2'b00, 0, 0, 0, 0, 0, 1,    0);
        run(5);

        // Reset during WAIT_RAM of STO
        do_reset();
        prog[0] = ins(STO, 9);
        rdy_q = '{1, 0, 0};
        push("sr_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("sr_exec",  0, 2'b00, 0, 0, 0, 1, 0, 9, 0);
        push("sr_wait",  0, 2'b00, 0, 0, 0, 1, 0, 9, 0);
        run(3);
        RamReady = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        RamReady = 1'b1;
        #1;
        push("sr_reset", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check_next();
        Reset = 1'b0;
        push("sr_refetch", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        run(1);

        // Reset from HALT
        do_reset();
        prog[0] = ins(HLT, 0);
        push("hr_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("hr_exec",  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("hr_halt",  0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        run(3);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        push("hr_reset", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check_next();
        Reset = 1'b0;

        // InstrValid low for five FETCH cycles, then opcode 11111 behaves as NOP
        do_reset();
        prog[0] = ins(NOPX, 42);
        vld_q = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) push("nv_stall", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("nv_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 0,  0);
        push("nv_nop",   0, 2'b00, 0, 0, 0, 0, 0, 42, 0);
        push("nv_next",  1, 2'b00, 0, 0, 0, 0, 0, 42, 0);
        run(8);

        n_tests++;
        assert (sbq.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drained: got %0d entries left required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_control_v2.md
BIP_CONTROL_V2 -- requirements
Module: bip_control_v2

Interface
REQ-001 SHALL have parameter PC_W, default 11, meaning program-counter, operand and Addr width.
REQ-002 SHALL have parameter OP_W, default 5, meaning opcode field width.
REQ-003 SHALL have parameter INSTR_W, default 16, meaning instruction width; INSTR_W = OP_W + PC_W is required, opcode in [INSTR_W-1 -: OP_W], operand in [PC_W-1:0].
REQ-004 Clk  in  1  single clock, all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high.
REQ-006 Instruction  in  INSTR_W  program-memory read data for Addr.
REQ-007 InstrValid  in  1  Instruction valid this cycle.
REQ-008 AccZero  in  1  accumulator equals zero.
REQ-009 AccNeg  in  1  accumulator MSB set.
REQ-010 RamReady  in  1  data-RAM access completes this cycle.
REQ-011 Addr  out  PC_W  program counter.
REQ-012 SelA  out  2  accumulator source: 00 RAM data, 01 operand, 10 ALU result.
REQ-013 SelB  out  1  ALU B source: 0 operand, 1 RAM data.
REQ-014 WrAcc  out  1  accumulator write strobe.
REQ-015 Op  out  1  ALU op: 0 add, 1 subtract.
REQ-016 WrRam, RdRam  out  1 each  data-RAM strobes.
REQ-017 Operand  out  PC_W  operand field of latched instruction (IR).
REQ-018 Halted  out  1  high while in HALT.

Function
REQ-019 SHALL implement states FETCH, EXEC, WAIT_RAM, HALT.
REQ-020 FETCH: Addr = PC; all strobes 0; on InstrValid=1 latch Instruction into IR and go EXEC; else remain.
REQ-021 Opcode map: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BLT, 01011 JMP; all others NOP.
REQ-022 Decode in EXEC/WAIT_RAM: STO WrRam=1; LD RdRam=1, SelA=00; LDI SelA=01; ADD/SUB RdRam=1, SelB=1, SelA=10; ADDI/SUBI SelB=0, SelA=10; Op=1 for SUB/SUBI only; unlisted outputs 0.
REQ-023 RAM instructions (STO, LD, ADD, SUB): if RamReady=1 in EXEC, complete that cycle; else go WAIT_RAM holding all decode outputs until the RamReady=1 cycle, which completes.
REQ-024 Completion cycle: WrAcc=1 for LD, LDI, ADD, ADDI, SUB, SUBI only; WrAcc SHALL never be 1 outside completion cycle.
REQ-025 Non-RAM instructions complete in their single EXEC cycle; minimum instruction time 2 cycles.
REQ-026 On completion: PC <= PC+1 modulo 2^PC_W (wrap 2^PC_W-1 -> 0), state FETCH.
REQ-027 Branches: BEQ taken if AccZero, BNE if !AccZero, BLT if AccNeg, JMP always; taken -> PC <= Operand, else PC+1; flags sampled in EXEC cycle.
REQ-028 HLT: in EXEC go HALT, PC unchanged; HALT holds all strobes 0, Halted=1, exits only via Reset.
REQ-029 RamReady SHALL be ignored in FETCH, HALT and for non-RAM instructions; InstrValid ignored outside FETCH.
REQ-030 Operand SHALL equal IR[PC_W-1:0] in all states.

Reset
REQ-031 Reset=1 at an edge SHALL set state FETCH, PC 0, IR 0, Operand 0, Halted 0, all strobes and SelA/SelB/Op 0, overriding any state including WAIT_RAM and HALT.
REQ-032 Reset mid-instruction SHALL abort it with no WrAcc/WrRam pulse on or after the reset edge.
REQ-033 After Reset deasserts, first fetch SHALL use Addr 0.

Verification
REQ-034 Program LDI 5, ADDI 3, STO 7, HLT with InstrValid=1, RamReady=1 -> WrAcc pulses at PC 0,1; WrRam=1 with Operand=7 at PC 2; Halted=1 with Addr=3 after 8 cycles.
REQ-035 LD 4 with RamReady low 3 cycles -> RdRam=1, SelA=00 held 4 EXEC/WAIT_RAM cycles, single WrAcc pulse on RamReady cycle, PC 0->1.
REQ-036 BEQ 20 with AccZero=1 -> Addr=20 next FETCH; AccZero=0 -> Addr=PC+1; same pair for BNE and BLT/AccNeg.
REQ-037 PC=2047 (PC_W=11), ADDI 1 -> next Addr 0; JMP 2047 reached and executed correctly.
REQ-038 Reset asserted during WAIT_RAM of STO -> WrRam 0 from reset edge, Addr 0, state FETCH; also from HALT -> Halted 0.
REQ-039 InstrValid held low 5 cycles in FETCH -> no strobes, IR unchanged, Addr stable; opcode 11111 -> NOP, PC+1 after 2 cycles.
